// File: rtl/prog_ram_ctrl.sv
// Program store and data RAM controller: switch loading (IN), inspection (CHECK)
// and registered CPU access (RUN), with debounce-free edge-detected keys.
module prog_ram_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int ROM_AW = 5,
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpustate,
  input  logic              A1,
  input  logic              A2,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic [DATA_W-1:0] check_out,
  output logic [ROM_AW-1:0] check_addr,
  output logic [ROM_AW:0]   prog_len,
  output logic              prog_full,
  output logic              wr_err
);

  localparam int ROM_D = 2 ** ROM_AW;
  localparam int RAM_D = 2 ** RAM_AW;

  typedef enum logic [1:0] {
    MODE_IDLE  = 2'b00,
    MODE_IN    = 2'b01,
    MODE_CHECK = 2'b10,
    MODE_RUN   = 2'b11
  } mode_e;

  mode_e mode, prev_mode;
  logic  in_mode, chk_mode, run_mode;

  assign mode     = mode_e'(cpustate);
  assign in_mode  = (mode == MODE_IN);
  assign chk_mode = (mode == MODE_CHECK);
  assign run_mode = (mode == MODE_RUN);

  logic [DATA_W-1:0] prog_mem [ROM_D];
  logic [DATA_W-1:0] ram_mem  [RAM_D];

  // Key edge detection
  logic a1_d1, a1_d2, a2_d1, a2_d2;
  logic a1_raw, a2_raw, a1_p, a2_p;

  // NOTE: key flops reset to 1 (released) so leaving reset with a key up cannot
  // manufacture a press pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a1_d1 <= 1'b1;
      a1_d2 <= 1'b1;
      a2_d1 <= 1'b1;
      a2_d2 <= 1'b1;
    end else begin
      a1_d1 <= A1;
      a1_d2 <= a1_d1;
      a2_d1 <= A2;
      a2_d2 <= a2_d1;
    end
  end

  assign a1_raw = ~a1_d1 & a1_d2;
  assign a2_raw = ~a2_d1 & a2_d2;
  // Simultaneous presses are ambiguous, so both are dropped.
  assign a1_p   = a1_raw & ~a2_raw;
  assign a2_p   = a2_raw & ~a1_raw;

  // Program write pointer / length
  logic [ROM_AW:0]   wptr;
  logic              store;
  logic [ROM_AW-1:0] last_idx;

  assign prog_full = (wptr == (ROM_AW + 1)'(ROM_D));
  assign prog_len  = wptr;
  assign store     = in_mode & a1_p & ~prog_full;
  assign last_idx  = ROM_AW'(wptr - 1'b1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr <= '0;
    end else if (store) begin
      wptr <= wptr + 1'b1;
    end else if (in_mode && a2_p && wptr != '0) begin
      wptr <= wptr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_mode <= MODE_IDLE;
    else        prev_mode <= mode;
  end

  // Check pointer wraps within the loaded length
  logic [ROM_AW-1:0] cptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cptr <= '0;
    end else if (chk_mode) begin
      if (prev_mode != MODE_CHECK || wptr == '0) begin
        cptr <= '0;
      end else if (a1_p) begin
        cptr <= (cptr == last_idx) ? '0 : cptr + 1'b1;
      end else if (a2_p) begin
        cptr <= (cptr == '0) ? last_idx : cptr - 1'b1;
      end
    end
  end

  assign check_addr = cptr;
  assign check_out  = chk_mode ? prog_mem[cptr] : '0;

  // RUN address decode: high bits above the RAM index alias
  logic                  is_prog;
  logic [ROM_AW-1:0]     prog_idx;
  logic [RAM_AW-1:0]     ram_idx;
  logic [DATA_W-1:0]     rd_word;
  logic                  ram_we;

  assign is_prog  = (addr[ADDR_W-1:ROM_AW] == '0);
  assign prog_idx = addr[ROM_AW-1:0];
  assign ram_idx  = addr[ROM_AW+RAM_AW-1:ROM_AW];
  assign rd_word  = is_prog ? prog_mem[prog_idx] : ram_mem[ram_idx];
  assign ram_we   = run_mode & write & ~is_prog;

  // NOTE: memory arrays carry no reset; clearing them would defeat RAM
  // inference, and the pointers already define what is valid.
  always_ff @(posedge clk) begin
    if (store) prog_mem[wptr[ROM_AW-1:0]] <= D;
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[ram_idx] <= data_in;
  end

  logic [DATA_W-1:0] data_q;
  logic              rd_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else if (!run_mode) begin
      data_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read;
      if (read) data_q <= rd_word;
    end
  end

  // Gate combinationally so the outputs drop the moment RUN is left.
  assign data_out = run_mode ? data_q : '0;
  assign rd_valid = run_mode & rd_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_err <= 1'b0;
    end else if (run_mode && write && is_prog) begin
      wr_err <= 1'b1;
    end else if (in_mode && prev_mode != MODE_IN) begin
      wr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_prog_ram_ctrl.sv
// Directed bench for prog_ram_ctrl: key loading, inspection wrap, RUN access
// through a read scoreboard, sticky write error and mid-operation reset.
module tb_prog_ram_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpustate;
  logic        A1, A2;
  logic [7:0]  D;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        read, write;
  logic [7:0]  data_out;
  logic        rd_valid;
  logic [7:0]  check_out;
  logic [4:0]  check_addr;
  logic [5:0]  prog_len;
  logic        prog_full;
  logic        wr_err;

  prog_ram_ctrl dut (
    .clk(clk), .reset(reset), .cpustate(cpustate), .A1(A1), .A2(A2), .D(D),
    .addr(addr), .data_in(data_in), .read(read), .write(write),
    .data_out(data_out), .rd_valid(rd_valid), .check_out(check_out),
    .check_addr(check_addr), .prog_len(prog_len), .prog_full(prog_full),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] m_prog [32];
  int         m_wptr = 0;
  logic [7:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // k=0 presses A1, k=1 presses A2, k=2 presses both together
  task automatic press(input int k, input int hold);
    @(negedge clk);
    if (k != 1) A1 = 1'b0;
    if (k != 0) A2 = 1'b0;
    repeat (hold) @(negedge clk);
    A1 = 1'b1;
    A2 = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic store(input logic [7:0] v, input int hold);
    D = v;
    press(0, hold);
    if (m_wptr < 32) begin
      m_prog[m_wptr] = v;
      m_wptr++;
    end
  endtask

  task automatic back();
    press(1, 1);
    if (m_wptr > 0) m_wptr--;
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; write = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] e;
    @(negedge clk);
    addr = a; read = 1'b1;
    sb_q.push_back(exp);
    check({tag, "_pre_valid"}, rd_valid, 0);
    @(negedge clk);
    read = 1'b0;
    check({tag, "_valid"}, rd_valid, 1);
    e = sb_q.pop_front();
    check({tag, "_data"}, data_out, e);
    @(negedge clk);
    check({tag, "_valid_drop"}, rd_valid, 0);
    check({tag, "_hold"}, data_out, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cpustate = 2'b00; A1 = 1'b1; A2 = 1'b1; D = '0;
    addr = '0; data_in = '0; read = 1'b0; write = 1'b0;
    #3;
    check("rst_data_out", data_out, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_prog_full", prog_full, 0);
    check("rst_prog_len", prog_len, 0);
    check("rst_check_addr", check_addr, 0);
    check("rst_check_out", check_out, 0);
    @(negedge clk);
    reset = 1'b1;
    cpustate = 2'b01;

    // Load three words; the last key is held for 10 cycles
    store(8'hA1, 1);
    check("load_len1", prog_len, m_wptr);
    store(8'hB2, 1);
    check("load_len2", prog_len, m_wptr);
    store(8'hC3, 10);
    check("load_len3_held", prog_len, 3);

    // Back then correct
    back();
    check("back_len", prog_len, 2);
    store(8'h55, 1);
    check("correct_len", prog_len, 3);

    // CHECK mode wrap
    @(negedge clk);
    cpustate = 2'b10;
    @(negedge clk);
    check("chk_entry_addr", check_addr, 0);
    check("chk_entry_out", check_out, 8'hA1);
    press(0, 1);
    check("chk_a1_1_addr", check_addr, 1);
    check("chk_a1_1_out", check_out, 8'hB2);
    press(0, 1);
    check("chk_a1_2_addr", check_addr, 2);
    check("chk_a1_2_out", check_out, 8'h55);
    press(0, 1);
    check("chk_wrap_addr", check_addr, 0);
    check("chk_wrap_out", check_out, 8'hA1);
    press(1, 1);
    check("chk_back_wrap_addr", check_addr, 2);
    check("chk_back_wrap_out", check_out, 8'h55);
    press(2, 1);
    check("chk_both_ignored", check_addr, 2);
    cpustate = 2'b00;
    @(negedge clk);
    check("idle_check_out", check_out, 0);
    check("idle_check_addr", check_addr, 2);
    cpustate = 2'b10;
    @(negedge clk);
    check("chk_reenter_addr", check_addr, 0);

    // RUN accesses
    cpustate = 2'b11;
    cpu_write(16'h0040, 8'h7E);
    cpu_read("rd_ram", 16'h0040, 8'h7E);
    cpu_read("rd_alias", 16'h8040, 8'h7E);
    cpu_read("rd_prog1", 16'h0001, m_prog[1]);
    check("wr_err_clear_before", wr_err, 0);
    cpu_write(16'h0003, 8'hAA);
    check("wr_err_set", wr_err, 1);
    cpu_write(16'h0002, 8'hAA);
    cpu_read("rd_prog2_unchanged", 16'h0002, 8'h55);
    check("wr_err_sticky", wr_err, 1);
    cpu_write(16'h0060, 8'h11);
    @(negedge clk);
    addr = 16'h0060; data_in = 8'h22; read = 1'b1; write = 1'b1;
    sb_q.push_back(8'h11);
    @(negedge clk);
    read = 1'b0; write = 1'b0;
    check("rw_same_valid", rd_valid, 1);
    check("rw_same_old", data_out, sb_q.pop_front());
    cpu_read("rd_after_rw", 16'h0060, 8'h22);
    press(0, 1);
    check("run_key_ignored", prog_len, 3);

    // Re-entering IN clears the error and forces outputs low
    cpustate = 2'b01;
    @(negedge clk);
    check("in_clears_wr_err", wr_err, 0);
    check("in_data_out_zero", data_out, 0);
    check("in_rd_valid_zero", rd_valid, 0);
    repeat (4) back();
    check("back_no_underflow", prog_len, 0);

    // Fill the program store
    for (int i = 0; i < 32; i++) begin
      store(8'(i * 9 + 5), 1);
      if (i == 30) check("not_full_31", prog_full, 0);
    end
    check("full_flag", prog_full, 1);
    check("full_len", prog_len, 32);
    store(8'hFF, 1);
    check("full_store_ignored", prog_len, 32);

    @(negedge clk);
    cpustate = 2'b10;
    @(negedge clk);
    check("full_chk0_out", check_out, m_prog[0]);
    press(1, 1);
    check("full_chk_back_addr", check_addr, 31);
    check("full_last_unchanged", check_out, m_prog[31]);
    press(0, 1);
    check("full_chk_wrap_addr", check_addr, 0);
    press(1, 1);

    // Reset in the middle of a RUN read
    cpustate = 2'b11;
    cpu_write(16'h0003, 8'h01);
    check("wr_err_set2", wr_err, 1);
    @(negedge clk);
    addr = 16'h0040; read = 1'b1;
    @(negedge clk);
    check("pre_reset_valid", rd_valid, 1);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_data_out", data_out, 0);
    check("mid_rst_rd_valid", rd_valid, 0);
    check("mid_rst_wr_err", wr_err, 0);
    check("mid_rst_prog_len", prog_len, 0);
    check("mid_rst_prog_full", prog_full, 0);
    check("mid_rst_check_addr", check_addr, 0);
    read = 1'b0;
    cpustate = 2'b01;
    m_wptr = 0;
    @(negedge clk);
    reset = 1'b1;

    // Reset while a key pulse is in flight
    store(8'h99, 1);
    check("post_rst_store", prog_len, 1);
    @(negedge clk);
    A1 = 1'b0;
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("key_rst_len", prog_len, 0);
    A1 = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    tick(4);
    check("no_spurious_pulse", prog_len, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
